// File: rtl/sad_accum.sv
// sad_accum: accumulates N absolute-difference samples into a SAD result,
// tracking the largest sample and the number of zero samples, then holds the
// result until the downstream consumer takes it.
module sad_accum #(
    parameter int unsigned DW = 4,
    parameter int unsigned N  = 8,
    parameter int unsigned SW = 7,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dif,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] sum,
    output logic [DW-1:0] max_dif,
    output logic [CW-1:0] zero_cnt,
    output logic          busy
);

    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [KW-1:0] cnt;

    // Block sequencing and result accumulation; results persist through IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sum      <= '0;
            max_dif  <= '0;
            zero_cnt <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sum      <= '0;
                        max_dif  <= '0;
                        zero_cnt <= '0;
                        cnt      <= '0;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        sum <= sum + SW'(dif);
                        if (dif > max_dif)
                            max_dif <= dif;
                        if (dif == '0)
                            zero_cnt <= zero_cnt + CW'(1);
                        if (cnt == KW'(N - 1)) begin
                            cnt   <= '0;
                            state <= HOLD;
                        end else begin
                            cnt <= cnt + KW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and status flags decode directly from the state register
    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == HOLD);
        busy      = (state == ACC) || (state == HOLD);
    end

endmodule

// File: tb/tb_sad_accum.sv
// tb_sad_accum: directed-vector bench for sad_accum with hand-computed results.
module tb_sad_accum;

    localparam int unsigned DW = 4;
    localparam int unsigned N  = 8;
    localparam int unsigned SW = 7;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dif;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] sum;
    logic [DW-1:0] max_dif;
    logic [CW-1:0] zero_cnt;
    logic          busy;

    int tests;
    int fails;

    sad_accum #(
        .DW(DW),
        .N (N),
        .SW(SW),
        .CW(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dif      (dif),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .max_dif  (max_dif),
        .zero_cnt (zero_cnt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("acc_in_ready", 32'(in_ready), 32'd1);
        check("acc_busy", 32'(busy), 32'd1);
    endtask

    // One accepted sample followed by gap idle cycles carrying a junk value
    task automatic feed(input logic [DW-1:0] d, input int gap);
        in_valid = 1'b1;
        dif      = d;
        tick();
        in_valid = 1'b0;
        dif      = 4'd9;
        repeat (gap) tick();
    endtask

    task automatic check_hold(input string tag, input int s, input int m, input int z);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(s));
        check({tag, "_max"}, 32'(max_dif), 32'(m));
        check({tag, "_zero"}, 32'(zero_cnt), 32'(z));
    endtask

    // Take the result and confirm return to IDLE with values retained
    task automatic finish_block(input string tag, input int s);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_sum_kept"}, 32'(sum), 32'(s));
    endtask

    initial begin
        logic [DW-1:0] v1 [8];
        logic [SW-1:0] snap;
        tests = 0;
        fails = 0;
        v1 = '{4'd9, 4'd6, 4'd0, 4'd12, 4'd1, 4'd2, 4'd3, 4'd4};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; dif = '0; out_ready = 1'b0;
        #1;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick(); tick();
        rst = 1'b0;

        // in_valid in IDLE must be ignored
        in_valid = 1'b1; dif = 4'd5;
        tick();
        in_valid = 1'b0;
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Mixed vector with out_ready held high throughout
        out_ready = 1'b1;
        do_start();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("v1_pre_last_out_valid", 32'(out_valid), 32'd0);
            feed(v1[i], 0);
        end
        check_hold("v1", 37, 12, 1);
        tick();
        out_ready = 1'b0;
        check("v1_idle_out_valid", 32'(out_valid), 32'd0);
        check("v1_idle_sum_kept", 32'(sum), 32'd37);

        // Full scale
        do_start();
        check("fs_cleared_sum", 32'(sum), 32'd0);
        for (int i = 0; i < 8; i++) feed(4'd15, 0);
        check_hold("fs", 120, 15, 0);
        finish_block("fs", 120);

        // All zero
        do_start();
        for (int i = 0; i < 8; i++) feed(4'd0, 0);
        check_hold("zero", 0, 0, 8);
        finish_block("zero", 0);

        // Gaps of 3 idle cycles between samples
        do_start();
        for (int i = 0; i < 8; i++) feed(4'd5, (i == 7) ? 0 : 3);
        check_hold("gap", 40, 5, 0);
        finish_block("gap", 40);

        // Backpressure in HOLD with noise on in_valid and start
        do_start();
        for (int i = 0; i < 8; i++) feed(4'd3, 0);
        check_hold("bp", 24, 3, 0);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            dif      = 4'd7;
            start    = (i % 2 == 0);
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum", 32'(sum), 32'd24);
        end
        in_valid = 1'b0;
        check("bp_max", 32'(max_dif), 32'd3);
        // start coinciding with the handshake is ignored
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_busy", 32'(busy), 32'd0);
        tick();
        check("bp_no_restart_busy", 32'(busy), 32'd0);

        // Asynchronous reset after 3 accepts
        do_start();
        for (int i = 0; i < 3; i++) feed(4'd9, 0);
        check("mid_partial_sum", 32'(sum), 32'd27);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_max", 32'(max_dif), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        do_start();
        for (int i = 0; i < 8; i++) feed(4'd1, 0);
        check_hold("post_rst", 8, 1, 0);
        finish_block("post_rst", 8);

        // start during ACC is ignored; counter and sum continue
        do_start();
        for (int i = 0; i < 4; i++) feed(4'd2, 0);
        snap = sum;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("accstart_sum", 32'(sum), 32'(snap));
        check("accstart_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) feed(4'd3, 0);
        check("accstart_not_done", 32'(out_valid), 32'd0);
        feed(4'd3, 0);
        check_hold("accstart", 20, 3, 0);
        finish_block("accstart", 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sad_accum.md
Name: sad_accum

Overview:
Sequential consumer placed directly downstream of abs_dif. Accepts a stream of 4-bit absolute differences (abs_dif.out) over a valid/ready handshake and accumulates N samples into a sum-of-absolute-differences (SAD) result. It also tracks the maximum difference and the count of zero differences (equal operand pairs), then holds the result until the consumer takes it.

Parameters:
DW, 4, width of each difference sample (matches abs_dif output width)
N, 8, samples per block; N >= 2
SW, 7, sum width; must be >= DW + ceil(log2(N)) (4+3 = 7 for the defaults)
CW, 4, zero-count width; must be >= ceil(log2(N+1))

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a new block; honoured only in IDLE
in_valid  input  1  dif is valid this cycle
in_ready  output  1  block accepts a sample this cycle
dif  input  DW  absolute difference sample (from abs_dif.out)
out_valid  output  1  sum/max_dif/zero_cnt hold a completed block result
out_ready  input  1  consumer takes the result
sum  output  SW  accumulated SAD of the block
max_dif  output  DW  largest dif in the block
zero_cnt  output  CW  number of samples with dif == 0
busy  output  1  high in ACC or HOLD

Behaviour:
- Reset is asynchronous and active-high. While rst=1, and immediately on its assertion: state=IDLE; sum=0, max_dif=0, zero_cnt=0, sample counter=0; in_ready=0, out_valid=0, busy=0.
- States are IDLE, ACC and HOLD.
- IDLE: in_ready=0, out_valid=0. If start=1 on a rising edge: clear sum, max_dif, zero_cnt and counter, then go to ACC. in_valid is ignored in IDLE.
- ACC: in_ready=1 and busy=1. A sample is accepted on each edge where in_valid && in_ready.
  - sum <= sum + dif, with dif zero-extended to SW bits.
  - max_dif <= max(max_dif, dif), unsigned compare.
  - zero_cnt increments when dif == 0.
  - The counter increments on each accept.
  - Cycles with in_valid=0 change nothing. Gaps of any length are legal.
- Last sample: on the edge that accepts sample N (counter == N-1), go to HOLD with the updated values.
  - out_valid=1 and in_ready=0 from the next cycle.
  - Latency is exactly 1 cycle from the last accept to out_valid.
- HOLD: out_valid=1, busy=1, all outputs stable. On an edge with out_ready=1 the transfer completes: go to IDLE with out_valid=0 next cycle.
  - sum, max_dif and zero_cnt keep their values in IDLE until the next start clears them.
- start outside IDLE is ignored. This includes start coinciding with the out_ready handshake in HOLD: the block goes to IDLE, and start must be re-asserted there.
- out_ready outside HOLD is ignored.
- No overflow is possible when the SW constraint holds. If SW is undersized, sum wraps modulo 2^SW; this is a configuration error, not runtime behaviour.
- Reset asserted mid-block (ACC or HOLD) abandons the block. No partial result is presented.
- Outputs are registered. There are no combinational paths from dif or in_valid to any output. in_ready and out_valid are pure functions of state.

Test Plan:
- Reset, then start, then 8 back-to-back samples 9,6,0,12,1,2,3,4 (outputs of abs_dif for pairs such as 3/12, 10/4, 5/5, 12/0) with out_ready=1 -> out_valid high exactly 1 cycle after the 8th accept; sum=37, max_dif=12, zero_cnt=1; IDLE on the next edge.
- 8 samples of 15 -> sum=120 (full-scale, no wrap), max_dif=15, zero_cnt=0. Then 8 samples of 0 -> sum=0, max_dif=0, zero_cnt=8.
- Gaps: samples 5,5,5,5,5,5,5,5 with in_valid low for 3 cycles between each -> sum=40, max_dif=5, zero_cnt=0. Idle cycles are not counted.
- Backpressure: hold out_ready=0 for 6 cycles in HOLD while driving in_valid=1, dif=7 and pulsing start -> in_ready=0, outputs unchanged, no new block starts. Raising out_ready -> out_valid drops the next cycle.
- Reset mid-op: assert rst asynchronously after 3 accepts (between clock edges) -> all outputs 0 immediately. A fresh start plus 8 samples of 1 -> sum=8, with no carry-over from the aborted block.
- start pulsed during ACC after sample 4 -> ignored. The block completes after 8 total accepts with the correct sum.
